// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the two-digit 7-segment scan multiplexer.
// Latency: n/a (types, constants and a polarity helper only).
// Backpressure: n/a.
package display_scan_mux_pkg;

  // Scan order: LEFT -> BLANK_L -> RIGHT -> BLANK_R -> LEFT ...
  typedef enum logic [1:0] {
    S_LEFT    = 2'd0,
    S_BLANK_L = 2'd1,
    S_RIGHT   = 2'd2,
    S_BLANK_R = 2'd3
  } scan_state_t;

  // One decoded display value: both digit patterns, {a..g}, 1 = lit.
  typedef struct packed {
    logic [6:0] left;
    logic [6:0] right;
  } digit_pair_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [1:0] DIG_LEFT  = 2'b10;
  localparam logic [1:0] DIG_RIGHT = 2'b01;
  localparam logic [1:0] DIG_NONE  = 2'b00;

  // Common-anode displays need the whole bus inverted, blanks included.
  function automatic logic [6:0] seg_pol(input logic [6:0] seg, input logic inv);
    return inv ? ~seg : seg;
  endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// scan_prescaler: free-running DIV_W-bit slot counter with clear/enable and terminal count.
// Latency: count updates on the clock edge after i_en; o_tc is combinational from the count.
// Backpressure: none; i_en=0 holds the count, i_clr has priority over i_en.
// Ports: clk, rst_n (async active-low), i_clr, i_en, o_tc (count == all ones).
module scan_prescaler #(
  parameter int DIV_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = &r_cnt;

endmodule

// File: rtl/display_scan_mux.sv
// display_scan_mux: scans two double-buffered 7-segment patterns onto one segment bus + 2 digit enables.
// Latency: all outputs registered, 1 cycle after the state/data they show; new data appears at frame start.
// Backpressure: none; ena=0 freezes the scan and blanks outputs, load is always accepted into pending.
// Ports: clk, rst_n (async active-low), ena, seg_left/seg_right[6:0], load (strobe),
//        seg_out[6:0] (polarity per ACTIVE_LOW_SEG), dig_sel[1:0] ([1]=left), frame_done (pulse).
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int DIV_W          = 10,
  parameter int BLANK_CYC      = 4,
  parameter int ACTIVE_LOW_SEG = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [6:0] seg_left,
  input  logic [6:0] seg_right,
  input  logic       load,
  output logic [6:0] seg_out,
  output logic [1:0] dig_sel,
  output logic       frame_done
);

  localparam logic       INV        = (ACTIVE_LOW_SEG != 0);
  localparam logic [6:0] SEG_OFF    = INV ? ~SEG_BLANK : SEG_BLANK;
  localparam logic       SKIP_BLANK = (BLANK_CYC == 0);
  localparam logic [7:0] BLANK_LAST = SKIP_BLANK ? 8'd0 : 8'(BLANK_CYC - 1);

  scan_state_t r_state;
  logic [7:0]  r_blank_cnt;
  digit_pair_t r_active;
  digit_pair_t r_pending;
  logic        r_pending_vld;
  logic        r_frame_pend;   // frame has started, pulse not yet shown
  logic [6:0]  r_seg;
  logic [1:0]  r_dig;
  logic        r_fd;

  logic        w_in_digit;
  logic        w_tc;
  logic        w_blank_done;
  logic        w_boundary;
  digit_pair_t w_in_pair;

  assign w_in_pair    = '{left: seg_left, right: seg_right};
  assign w_in_digit   = ena && (r_state == S_LEFT || r_state == S_RIGHT);
  // With no blanking the reset state still leaves on the first enabled edge.
  assign w_blank_done = SKIP_BLANK || (r_blank_cnt == BLANK_LAST);
  // Frame boundary: entering S_LEFT from the right half of the frame.
  assign w_boundary   = ena && ((r_state == S_BLANK_R && w_blank_done) ||
                                (SKIP_BLANK && r_state == S_RIGHT && w_tc));

  // Prescaler is cleared on leaving a digit slot, so it is zero on every entry.
  scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_in_digit && w_tc),
    .i_en  (w_in_digit),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_BLANK_R;
      r_blank_cnt   <= 8'd0;
      r_active      <= '0;
      r_pending     <= '0;
      r_pending_vld <= 1'b0;
      r_frame_pend  <= 1'b0;
      r_seg         <= SEG_OFF;
      r_dig         <= DIG_NONE;
      r_fd          <= 1'b0;
    end else begin
      // Registered outputs from the current (pre-transition) state.
      r_seg <= SEG_OFF;
      r_dig <= DIG_NONE;
      r_fd  <= 1'b0;
      if (ena) begin
        case (r_state)
          S_LEFT: begin
            r_seg <= seg_pol(r_active.left, INV);
            r_dig <= DIG_LEFT;
            r_fd  <= r_frame_pend;
          end
          S_RIGHT: begin
            r_seg <= seg_pol(r_active.right, INV);
            r_dig <= DIG_RIGHT;
          end
          default: ;
        endcase
      end

      // Scan sequencing; everything holds while ena=0.
      if (ena) begin
        case (r_state)
          S_LEFT:    if (w_tc) r_state <= SKIP_BLANK ? S_RIGHT : S_BLANK_L;
          S_RIGHT:   if (w_tc) r_state <= SKIP_BLANK ? S_LEFT : S_BLANK_R;
          S_BLANK_L: begin
            if (w_blank_done) begin
              r_blank_cnt <= 8'd0;
              r_state     <= S_RIGHT;
            end else begin
              r_blank_cnt <= r_blank_cnt + 8'd1;
            end
          end
          default: begin
            if (w_blank_done) begin
              r_blank_cnt <= 8'd0;
              r_state     <= S_LEFT;
            end else begin
              r_blank_cnt <= r_blank_cnt + 8'd1;
            end
          end
        endcase
      end

      // Pulse is held pending until the first enabled cycle in S_LEFT shows it.
      if (w_boundary) begin
        r_frame_pend <= 1'b1;
      end else if (ena && r_state == S_LEFT) begin
        r_frame_pend <= 1'b0;
      end

      // Double buffer: active only changes at the boundary; a load on that cycle wins.
      if (load) begin
        r_pending <= w_in_pair;
      end
      if (w_boundary) begin
        if (load) begin
          r_active <= w_in_pair;
        end else if (r_pending_vld) begin
          r_active <= r_pending;
        end
        r_pending_vld <= 1'b0;
      end else if (load) begin
        r_pending_vld <= 1'b1;
      end
    end
  end

  assign seg_out    = r_seg;
  assign dig_sel    = r_dig;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_display_scan_mux.sv
module tb_display_scan_mux;

  localparam int SLOT   = 4;   // 2**DIV_W with DIV_W=2
  localparam int BLANK  = 2;
  localparam int PERIOD = 2 * (SLOT + BLANK);

  localparam logic [6:0] L1 = 7'b0110000;
  localparam logic [6:0] R1 = 7'b1111110;
  localparam logic [6:0] L2 = 7'b1101101;
  localparam logic [6:0] R2 = 7'b1111001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       load;
  logic [6:0] seg_left;
  logic [6:0] seg_right;
  logic [6:0] seg_out,  seg_out_al;
  logic [1:0] dig_sel,  dig_sel_al;
  logic       frame_done, frame_done_al;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  display_scan_mux #(.DIV_W(2), .BLANK_CYC(2), .ACTIVE_LOW_SEG(0)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_left(seg_left), .seg_right(seg_right),
    .load(load), .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
  );

  display_scan_mux #(.DIV_W(2), .BLANK_CYC(2), .ACTIVE_LOW_SEG(1)) dut_al (
    .clk(clk), .rst_n(rst_n), .ena(ena), .seg_left(seg_left), .seg_right(seg_right),
    .load(load), .seg_out(seg_out_al), .dig_sel(dig_sel_al), .frame_done(frame_done_al)
  );

  // Reference model: position within the frame, 0..PERIOD-1.
  int         m_pos;
  logic [6:0] m_act_l, m_act_r, m_pend_l, m_pend_r;
  logic       m_pend_v;
  logic [1:0] e_dig;
  logic [6:0] e_seg;
  logic       e_fd;

  task automatic model_reset();
    m_pos = PERIOD - BLANK;   // reset sits at the start of the right-hand blank
    m_act_l = 7'h00; m_act_r = 7'h00; m_pend_l = 7'h00; m_pend_r = 7'h00;
    m_pend_v = 1'b0;
    e_dig = 2'b00; e_seg = 7'h00; e_fd = 1'b0;
  endtask

  task automatic model_step();
    logic bnd;
    e_dig = 2'b00; e_seg = 7'h00; e_fd = 1'b0;
    if (ena) begin
      if (m_pos < SLOT) begin
        e_dig = 2'b10; e_seg = m_act_l; e_fd = (m_pos == 0);
      end else if (m_pos >= SLOT + BLANK && m_pos < 2 * SLOT + BLANK) begin
        e_dig = 2'b01; e_seg = m_act_r;
      end
    end
    bnd = ena && (m_pos == PERIOD - 1);
    if (ena) m_pos = (m_pos + 1) % PERIOD;
    if (bnd) begin
      if (load) begin
        m_act_l = seg_left; m_act_r = seg_right;
      end else if (m_pend_v) begin
        m_act_l = m_pend_l; m_act_r = m_pend_r;
      end
      m_pend_v = 1'b0;
    end
    if (load) begin
      m_pend_l = seg_left; m_pend_r = seg_right;
      if (!bnd) m_pend_v = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare both DUTs.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("model_dig",    {6'b0, dig_sel},       {6'b0, e_dig});
    chk("model_seg",    {1'b0, seg_out},       {1'b0, e_seg});
    chk("model_fd",     {7'b0, frame_done},    {7'b0, e_fd});
    chk("model_dig_al", {6'b0, dig_sel_al},    {6'b0, e_dig});
    chk("model_seg_al", {1'b0, seg_out_al},    {1'b0, ~e_seg});
    chk("model_fd_al",  {7'b0, frame_done_al}, {7'b0, e_fd});
  endtask

  typedef struct {
    logic       ena;
    logic       load;
    logic [6:0] l;
    logic [6:0] r;
    logic [1:0] dig;
    logic [6:0] seg;
    logic       fd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic ld, input logic [6:0] l, input logic [6:0] r,
                     input logic [1:0] dig, input logic [6:0] seg, input logic fd, input int n);
    vec_t v;
    v.ena = e; v.load = ld; v.l = l; v.r = r; v.dig = dig; v.seg = seg; v.fd = fd;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    ena = 1'b0; load = 1'b0; seg_left = 7'h00; seg_right = 7'h00;
    rst_n = 1'b1;
    model_reset();

    // Reset asserted before any clock edge: outputs must already be OFF.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dig",    {6'b0, dig_sel},       8'h00);
    chk("rst_seg",    {1'b0, seg_out},       8'h00);
    chk("rst_fd",     {7'b0, frame_done},    8'h00);
    chk("rst_seg_al", {1'b0, seg_out_al},    8'h7F);
    chk("rst_dig_al", {6'b0, dig_sel_al},    8'h00);

    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;

    // Directed table: reset release, mid-frame load, boundary load, ena freeze.
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);   // reset blank
    add(1, 0, 0,  0,  2'b10, 7'h00, 1, 1);   // first frame starts
    add(1, 1, L1, R1, 2'b10, 7'h00, 0, 1);   // mid-frame load: no visible change
    add(1, 0, 0,  0,  2'b10, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b01, 7'h00, 0, 4);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b10, L1,    1, 1);   // loaded data shown from the next frame
    add(1, 0, 0,  0,  2'b10, L1,    0, 3);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b01, R1,    0, 4);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 1);
    add(1, 1, L2, R2, 2'b00, 7'h00, 0, 1);   // load on the boundary cycle
    add(1, 0, 0,  0,  2'b10, L2,    1, 1);   // bypassed into the same frame
    add(1, 0, 0,  0,  2'b10, L2,    0, 3);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b01, R2,    0, 4);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b10, L2,    1, 1);   // no extra update afterwards
    add(1, 0, 0,  0,  2'b10, L2,    0, 3);
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b01, R2,    0, 2);   // two cycles of the right digit
    add(0, 0, 0,  0,  2'b00, 7'h00, 0, 5);   // frozen and blanked
    add(1, 0, 0,  0,  2'b01, R2,    0, 2);   // remaining right-slot count
    add(1, 0, 0,  0,  2'b00, 7'h00, 0, 2);
    add(1, 0, 0,  0,  2'b10, L2,    1, 1);

    foreach (tbl[i]) begin
      ena = tbl[i].ena; load = tbl[i].load; seg_left = tbl[i].l; seg_right = tbl[i].r;
      tick();
      chk($sformatf("tbl%0d_dig", i),    {6'b0, dig_sel},    {6'b0, tbl[i].dig});
      chk($sformatf("tbl%0d_seg", i),    {1'b0, seg_out},    {1'b0, tbl[i].seg});
      chk($sformatf("tbl%0d_fd", i),     {7'b0, frame_done}, {7'b0, tbl[i].fd});
      chk($sformatf("tbl%0d_seg_al", i), {1'b0, seg_out_al}, {1'b0, ~tbl[i].seg});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ena       = ($urandom_range(0, 7) != 0);
      load      = ($urandom_range(0, 9) == 0);
      seg_left  = 7'($urandom);
      seg_right = 7'($urandom);
      tick();
    end

    // Async reset in S_RIGHT while pending data is waiting.
    ena = 1'b1; load = 1'b0;
    for (int k = 0; k < 2 * PERIOD && m_pos != SLOT + BLANK; k++) tick();
    load = 1'b1; seg_left = 7'h5A; seg_right = 7'h33;
    tick();
    load = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_dig",    {6'b0, dig_sel},    8'h00);
    chk("arst_seg",    {1'b0, seg_out},    8'h00);
    chk("arst_fd",     {7'b0, frame_done}, 8'h00);
    chk("arst_seg_al", {1'b0, seg_out_al}, 8'h7F);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_dig", {6'b0, dig_sel},    8'h02);
    chk("post_rst_seg", {1'b0, seg_out},    8'h00);
    chk("post_rst_fd",  {7'b0, frame_done}, 8'h01);
    for (int k = 0; k < PERIOD + 2; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
